// File: rtl/data_mem_arbiter_if.sv
// Consumer/memory bundle for the shared data memory arbiter.
// Ports (per signal group):
//   consumer_read_*  : per-LSU read request, completion and returned data
//   consumer_write_* : per-LSU write request and completion
//   mem_read_*       : single read channel towards data memory
//   mem_write_*      : single write channel towards data memory
// Per-consumer fields are flat packed; consumer c owns slice c.
// The master modport is the arbiter view; slave is the environment view.

interface data_mem_arbiter_if #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4
);
    logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;

    logic [NUM_CONSUMERS-1:0]           consumer_write_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data;
    logic [NUM_CONSUMERS-1:0]           consumer_write_ready;

    logic                               mem_read_valid;
    logic [ADDR_BITS-1:0]               mem_read_address;
    logic                               mem_read_ready;
    logic [DATA_BITS-1:0]               mem_read_data;

    logic                               mem_write_valid;
    logic [ADDR_BITS-1:0]               mem_write_address;
    logic [DATA_BITS-1:0]               mem_write_data;
    logic                               mem_write_ready;

    modport master (
        input  consumer_read_valid,
        input  consumer_read_address,
        output consumer_read_ready,
        output consumer_read_data,
        input  consumer_write_valid,
        input  consumer_write_address,
        input  consumer_write_data,
        output consumer_write_ready,
        output mem_read_valid,
        output mem_read_address,
        input  mem_read_ready,
        input  mem_read_data,
        output mem_write_valid,
        output mem_write_address,
        output mem_write_data,
        input  mem_write_ready
    );

    modport slave (
        output consumer_read_valid,
        output consumer_read_address,
        input  consumer_read_ready,
        input  consumer_read_data,
        output consumer_write_valid,
        output consumer_write_address,
        output consumer_write_data,
        input  consumer_write_ready,
        input  mem_read_valid,
        input  mem_read_address,
        output mem_read_ready,
        output mem_read_data,
        input  mem_write_valid,
        input  mem_write_address,
        input  mem_write_data,
        output mem_write_ready
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one data memory channel among LSU consumers.
// Ports: clk, reset (async, active-high), bus (data_mem_arbiter_if.master),
//        busy (not IDLE), grant_id (granted consumer, 0 when idle).

module data_mem_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4
) (
    input  logic               clk,
    input  logic               reset,
    data_mem_arbiter_if.master bus,
    output logic               busy,
    output logic [3:0]         grant_id
);
    localparam int IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_CONSUMERS - 1);
    localparam logic [IDX_W:0]   NUM_W = (IDX_W + 1)'(NUM_CONSUMERS);

    typedef enum logic [1:0] {
        IDLE,
        READ_WAITING,
        WRITE_WAITING,
        RELAYING
    } state_t;

    state_t                       state;
    logic [IDX_W-1:0]             rr_ptr;
    logic [IDX_W-1:0]             gsel;
    logic                         served_write;

    logic [NUM_CONSUMERS-1:0]     rd_ready_q;
    logic [NUM_CONSUMERS-1:0]     wr_ready_q;
    logic [DATA_BITS-1:0]         rd_data_q [NUM_CONSUMERS];

    logic                         mem_rv_q;
    logic [ADDR_BITS-1:0]         mem_ra_q;
    logic                         mem_wv_q;
    logic [ADDR_BITS-1:0]         mem_wa_q;
    logic [DATA_BITS-1:0]         mem_wd_q;

    logic [ADDR_BITS-1:0]         rd_addr [NUM_CONSUMERS];
    logic [ADDR_BITS-1:0]         wr_addr [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]         wr_data [NUM_CONSUMERS];
    logic [NUM_CONSUMERS*DATA_BITS-1:0] rd_data_flat;

    logic                         pick_found;
    logic                         pick_write;
    logic [IDX_W-1:0]             pick_idx;
    logic [IDX_W:0]               cand;
    logic                         served_low;

    // Unpack the flat consumer buses into per-consumer views.
    for (genvar c = 0; c < NUM_CONSUMERS; c++) begin : g_slice
        assign rd_addr[c] =
            bus.consumer_read_address[c*ADDR_BITS +: ADDR_BITS];
        assign wr_addr[c] =
            bus.consumer_write_address[c*ADDR_BITS +: ADDR_BITS];
        assign wr_data[c] =
            bus.consumer_write_data[c*DATA_BITS +: DATA_BITS];
    end

    always_comb begin
        rd_data_flat = '0;
        for (int c = 0; c < NUM_CONSUMERS; c++) begin
            rd_data_flat[c*DATA_BITS +: DATA_BITS] = rd_data_q[c];
        end
    end

    assign bus.consumer_read_data   = rd_data_flat;
    assign bus.consumer_read_ready  = rd_ready_q;
    assign bus.consumer_write_ready = wr_ready_q;
    assign bus.mem_read_valid       = mem_rv_q;
    assign bus.mem_read_address     = mem_ra_q;
    assign bus.mem_write_valid      = mem_wv_q;
    assign bus.mem_write_address    = mem_wa_q;
    assign bus.mem_write_data       = mem_wd_q;

    // Scan from rr_ptr upward with wrap; the first requester wins.
    // A consumer with both requests up is served its read first.
    always_comb begin
        pick_found = 1'b0;
        pick_write = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            cand = {1'b0, rr_ptr} + (IDX_W + 1)'(i);
            if (cand >= NUM_W) begin
                cand = cand - NUM_W;
            end
            if (!pick_found &&
                (bus.consumer_read_valid[cand[IDX_W-1:0]] ||
                 bus.consumer_write_valid[cand[IDX_W-1:0]])) begin
                pick_found = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
                pick_write = !bus.consumer_read_valid[cand[IDX_W-1:0]];
            end
        end
    end

    // Release condition: the valid of the kind just served has dropped.
    assign served_low = served_write ?
        !bus.consumer_write_valid[gsel] :
        !bus.consumer_read_valid[gsel];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            gsel         <= '0;
            served_write <= 1'b0;
            busy         <= 1'b0;
            grant_id     <= '0;
            rd_ready_q   <= '0;
            wr_ready_q   <= '0;
            mem_rv_q     <= 1'b0;
            mem_ra_q     <= '0;
            mem_wv_q     <= 1'b0;
            mem_wa_q     <= '0;
            mem_wd_q     <= '0;
            for (int c = 0; c < NUM_CONSUMERS; c++) begin
                rd_data_q[c] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_found) begin
                        gsel     <= pick_idx;
                        grant_id <= 4'(pick_idx);
                        busy     <= 1'b1;
                        if (pick_write) begin
                            served_write <= 1'b1;
                            mem_wv_q     <= 1'b1;
                            mem_wa_q     <= wr_addr[pick_idx];
                            mem_wd_q     <= wr_data[pick_idx];
                            state        <= WRITE_WAITING;
                        end else begin
                            served_write <= 1'b0;
                            mem_rv_q     <= 1'b1;
                            mem_ra_q     <= rd_addr[pick_idx];
                            state        <= READ_WAITING;
                        end
                    end
                end
                // Consumer valids are ignored here: once issued, the
                // memory transaction always completes.
                READ_WAITING: begin
                    if (bus.mem_read_ready) begin
                        rd_data_q[gsel]  <= bus.mem_read_data;
                        rd_ready_q[gsel] <= 1'b1;
                        mem_rv_q         <= 1'b0;
                        state            <= RELAYING;
                    end
                end
                WRITE_WAITING: begin
                    if (bus.mem_write_ready) begin
                        wr_ready_q[gsel] <= 1'b1;
                        mem_wv_q         <= 1'b0;
                        state            <= RELAYING;
                    end
                end
                RELAYING: begin
                    if (served_low) begin
                        rd_ready_q <= '0;
                        wr_ready_q <= '0;
                        rr_ptr     <= (gsel == LAST) ? '0 : gsel + 1'b1;
                        grant_id   <= '0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small memory model.
// Unwritten memory reads return address ^ 8'h2F.

module tb_data_mem_arbiter;
    localparam int AB = 8;
    localparam int DB = 8;
    localparam int NC = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       busy;
    logic [3:0] grant_id;

    always #5 clk = ~clk;

    data_mem_arbiter_if #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC)
    ) bus ();

    data_mem_arbiter #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.master),
        .busy    (busy),
        .grant_id(grant_id)
    );

    logic [NC-1:0] rv;
    logic [NC-1:0] wv;
    logic [AB-1:0] ra   [NC];
    logic [AB-1:0] wa   [NC];
    logic [DB-1:0] wdat [NC];
    logic          mrr;
    logic          mwr;
    logic [DB-1:0] mem  [256];
    logic [255:0]  wrote = '0;
    logic [DB-1:0] rdq  [NC];

    int n_vec = 0;
    int n_err = 0;

    assign bus.consumer_read_valid    = rv;
    assign bus.consumer_write_valid   = wv;
    assign bus.consumer_read_address  = {ra[3], ra[2], ra[1], ra[0]};
    assign bus.consumer_write_address = {wa[3], wa[2], wa[1], wa[0]};
    assign bus.consumer_write_data    = {wdat[3], wdat[2], wdat[1], wdat[0]};
    assign bus.mem_read_ready         = mrr;
    assign bus.mem_write_ready        = mwr;
    assign bus.mem_read_data = wrote[bus.mem_read_address] ?
        mem[bus.mem_read_address] : (bus.mem_read_address ^ 8'h2F);

    always @(posedge clk) begin
        if (bus.mem_write_valid && bus.mem_write_ready) begin
            mem[bus.mem_write_address]   <= bus.mem_write_data;
            wrote[bus.mem_write_address] <= 1'b1;
        end
    end

    for (genvar g = 0; g < NC; g++) begin : g_rd
        assign rdq[g] = bus.consumer_read_data[g*DB +: DB];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expects the read request of consumer c to be granted at the next edge.
    task automatic serve_read(input logic [1:0] c, input logic [7:0] a,
                              input logic [7:0] d);
        step();
        chk("rd_gnt", 32'(grant_id), 32'(c));
        chk("rd_busy", 32'(busy), 32'd1);
        chk("rd_mv", 32'(bus.mem_read_valid), 32'd1);
        chk("rd_ma", 32'(bus.mem_read_address), 32'(a));
        step();
        chk("rd_rdy", 32'(bus.consumer_read_ready), 32'(4'b0001 << c));
        chk("rd_dat", 32'(rdq[c]), 32'(d));
        chk("rd_mv0", 32'(bus.mem_read_valid), 32'd0);
        rv[c] = 1'b0;
        step();
        chk("rd_rel", 32'(bus.consumer_read_ready), 32'd0);
        chk("rd_idle", 32'({busy, grant_id}), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        rv    = '0;
        wv    = '0;
        mrr   = 1'b1;
        mwr   = 1'b1;
        for (int i = 0; i < NC; i++) begin
            ra[i]   = '0;
            wa[i]   = '0;
            wdat[i] = '0;
        end
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gnt", 32'(grant_id), 32'd0);
        chk("rst_mrv", 32'(bus.mem_read_valid), 32'd0);
        chk("rst_mwv", 32'(bus.mem_write_valid), 32'd0);
        chk("rst_rdy", 32'({bus.consumer_read_ready,
                            bus.consumer_write_ready}), 32'd0);
        chk("rst_addr", 32'({bus.mem_read_address,
                             bus.mem_write_address,
                             bus.mem_write_data}), 32'd0);
        chk("rst_rdat", bus.consumer_read_data, 32'd0);
        step();
        step();
        reset = 1'b0;

        // Single read by consumer 2
        ra[2] = 8'h05;
        rv[2] = 1'b1;
        serve_read(2'd2, 8'h05, 8'h2A);

        // rr_ptr now 3: consumer 3 beats consumer 0
        ra[0] = 8'h30;
        ra[3] = 8'h31;
        rv[0] = 1'b1;
        rv[3] = 1'b1;
        serve_read(2'd3, 8'h31, 8'h1E);
        serve_read(2'd0, 8'h30, 8'h1F);
        chk("hold2", 32'(rdq[2]), 32'h2A);

        // Asynchronous reset pulse between edges
        reset = 1'b1;
        #2;
        reset = 1'b0;

        // All four request together from rr_ptr 0
        for (int i = 0; i < NC; i++) begin
            ra[i] = 8'(8'h20 + i);
        end
        rv = 4'hF;
        serve_read(2'd0, 8'h20, 8'h0F);
        serve_read(2'd1, 8'h21, 8'h0E);
        serve_read(2'd2, 8'h22, 8'h0D);
        serve_read(2'd3, 8'h23, 8'h0C);
        ra[0] = 8'h30;
        ra[3] = 8'h31;
        rv[0] = 1'b1;
        rv[3] = 1'b1;
        serve_read(2'd0, 8'h30, 8'h1F);
        serve_read(2'd3, 8'h31, 8'h1E);

        // Consumer drops valid while waiting on memory
        mrr   = 1'b0;
        ra[1] = 8'h40;
        rv[1] = 1'b1;
        step();
        chk("drop_gnt", 32'(grant_id), 32'd1);
        rv[1] = 1'b0;
        step();
        chk("drop_wait", 32'(bus.consumer_read_ready), 32'd0);
        chk("drop_mv", 32'(bus.mem_read_valid), 32'd1);
        chk("drop_ma", 32'(bus.mem_read_address), 32'h40);
        mrr = 1'b1;
        step();
        chk("drop_rdy", 32'(bus.consumer_read_ready), 32'b0010);
        chk("drop_dat", 32'(rdq[1]), 32'h6F);
        step();
        chk("drop_idle", 32'({busy, bus.consumer_read_ready}), 32'd0);

        // Write by consumer 1 with memory stalling three cycles
        mwr     = 1'b0;
        wa[1]   = 8'h10;
        wdat[1] = 8'h77;
        wv[1]   = 1'b1;
        step();
        chk("wr_gnt", 32'(grant_id), 32'd1);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) step();
            chk("wr_mwv", 32'(bus.mem_write_valid), 32'd1);
            chk("wr_mwa", 32'(bus.mem_write_address), 32'h10);
            chk("wr_mwd", 32'(bus.mem_write_data), 32'h77);
            chk("wr_nrdy", 32'(bus.consumer_write_ready), 32'd0);
        end
        mwr = 1'b1;
        step();
        chk("wr_rdy", 32'(bus.consumer_write_ready), 32'b0010);
        chk("wr_mwv0", 32'(bus.mem_write_valid), 32'd0);
        chk("wr_mem", 32'(mem[8'h10]), 32'h77);
        wv[1] = 1'b0;
        step();
        chk("wr_rel", 32'({busy, bus.consumer_write_ready}), 32'd0);
        ra[2] = 8'h10;
        rv[2] = 1'b1;
        serve_read(2'd2, 8'h10, 8'h77);

        // Consumer 0 reads and writes together: read first
        ra[0]   = 8'h50;
        wa[0]   = 8'h51;
        wdat[0] = 8'hC3;
        rv[0]   = 1'b1;
        wv[0]   = 1'b1;
        serve_read(2'd0, 8'h50, 8'h7F);
        step();
        chk("rw_gnt", 32'(grant_id), 32'd0);
        chk("rw_mv", 32'({bus.mem_write_valid, bus.mem_read_valid}),
            32'b10);
        chk("rw_wa", 32'(bus.mem_write_address), 32'h51);
        chk("rw_wd", 32'(bus.mem_write_data), 32'hC3);
        step();
        chk("rw_rdy", 32'(bus.consumer_write_ready), 32'b0001);
        wv[0] = 1'b0;
        step();
        chk("rw_idle", 32'({busy, bus.consumer_write_ready}), 32'd0);

        // Reset while READ_WAITING
        mrr   = 1'b0;
        ra[1] = 8'h60;
        rv[1] = 1'b1;
        step();
        chk("ab_mv", 32'(bus.mem_read_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ab_mv0", 32'(bus.mem_read_valid), 32'd0);
        chk("ab_ma0", 32'(bus.mem_read_address), 32'd0);
        chk("ab_busy", 32'({busy, grant_id}), 32'd0);
        chk("ab_rdat", bus.consumer_read_data, 32'd0);
        rv[1] = 1'b0;
        mrr   = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("ab_nordy", 32'({busy, bus.consumer_read_ready}), 32'd0);
        end

        // Consumer 3 holds its request while 0..2 keep re-requesting
        for (int i = 0; i < NC; i++) begin
            ra[i] = 8'(8'h20 + i);
        end
        rv = 4'hF;
        serve_read(2'd0, 8'h20, 8'h0F);
        rv[0] = 1'b1;
        serve_read(2'd1, 8'h21, 8'h0E);
        rv[1] = 1'b1;
        serve_read(2'd2, 8'h22, 8'h0D);
        rv[2] = 1'b1;
        serve_read(2'd3, 8'h23, 8'h0C);
        serve_read(2'd0, 8'h20, 8'h0F);
        rv = '0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001: Parameter ADDR_BITS, default 8, memory address width.
REQ-002: Parameter DATA_BITS, default 8, memory data width.
REQ-003: Parameter NUM_CONSUMERS, default 4, number of LSU requesters sharing one data memory channel; legal range 2..16.
REQ-004: clk  input  1  single clock; all state updates on its rising edge.
REQ-005: reset  input  1  asynchronous, active-high reset.
REQ-006: consumer_read_valid  input  NUM_CONSUMERS  per-consumer read request.
REQ-007: consumer_read_address  input  NUM_CONSUMERS*ADDR_BITS  flat packed addresses; consumer c occupies bits [(c+1)*ADDR_BITS-1 : c*ADDR_BITS].
REQ-008: consumer_read_ready  output  NUM_CONSUMERS  per-consumer read completion.
REQ-009: consumer_read_data  output  NUM_CONSUMERS*DATA_BITS  flat packed read data, same packing as REQ-007.
REQ-010: consumer_write_valid  input  NUM_CONSUMERS  per-consumer write request.
REQ-011: consumer_write_address  input  NUM_CONSUMERS*ADDR_BITS  flat packed write addresses.
REQ-012: consumer_write_data  input  NUM_CONSUMERS*DATA_BITS  flat packed write data.
REQ-013: consumer_write_ready  output  NUM_CONSUMERS  per-consumer write completion.
REQ-014: mem_read_valid / mem_read_address  output  1 / ADDR_BITS  read request to memory.
REQ-015: mem_read_ready / mem_read_data  input  1 / DATA_BITS  memory read response.
REQ-016: mem_write_valid / mem_write_address / mem_write_data  output  1 / ADDR_BITS / DATA_BITS  write request to memory.
REQ-017: mem_write_ready  input  1  memory write acknowledge.
REQ-018: busy  output  1  high in any state other than IDLE.
REQ-019: grant_id  output  4  index of consumer currently granted; 0 when idle.

Function
REQ-020: FSM states SHALL be IDLE, READ_WAITING, WRITE_WAITING, RELAYING; all outputs registered.
REQ-021: IDLE: scan consumers starting at rr_ptr, ascending, wrapping NUM_CONSUMERS-1 -> 0; first consumer with read_valid or write_valid is granted at that edge.
REQ-022: Same consumer with read_valid and write_valid both high: read served first; write remains pending.
REQ-023: On read grant: latch grant_id, mem_read_valid=1, mem_read_address=consumer address; -> READ_WAITING.
REQ-024: On write grant: mem_write_valid=1, address and data latched from consumer; -> WRITE_WAITING.
REQ-025: READ_WAITING: on edge with mem_read_ready=1, capture mem_read_data into granted slice of consumer_read_data, consumer_read_ready[grant]=1, mem_read_valid=0; -> RELAYING.
REQ-026: WRITE_WAITING: on edge with mem_write_ready=1, consumer_write_ready[grant]=1, mem_write_valid=0; -> RELAYING.
REQ-027: Memory address/data outputs SHALL stay stable while the corresponding mem valid is high.
REQ-028: Consumer valid deassertion during *_WAITING is ignored; memory transaction completes and ready is still issued.
REQ-029: RELAYING: hold the served ready until the served-type valid of the granted consumer is sampled low; then ready=0, rr_ptr=(grant+1) mod NUM_CONSUMERS; -> IDLE.
REQ-030: consumer_read_data slice SHALL hold its last captured value until overwritten by a later read to that consumer.
REQ-031: Latency with always-ready memory: request sampled edge k, mem valid high after k, consumer ready high after k+1, IDLE after edge where valid seen low; at most one transaction in flight.
REQ-032: Fairness: a continuously requesting consumer SHALL be granted within NUM_CONSUMERS arbitration rounds.

Reset
REQ-033: reset=1 SHALL immediately force state IDLE, rr_ptr=0, grant_id=0, busy=0, all valid/ready outputs 0, all data/address outputs 0, regardless of clock.
REQ-034: Reset mid-transaction abandons it; no ready is issued for it after release.

Verification
REQ-035: Single read: consumer 2 reads addr 0x05 (mem[5]=0x2A), memory always ready -> mem_read_valid 1 cycle, consumer_read_ready[2]=1, data slice 2 = 0x2A, IDLE, rr_ptr=3.
REQ-036: All 4 consumers read simultaneously from rr_ptr=0 -> grants in order 0,1,2,3, each with correct data; then rr_ptr=0.
REQ-037: Consumer 1 write addr 0x10 data 0x77 with mem_write_ready low 3 cycles -> mem_write_valid/address/data held stable 3 cycles, write_ready[1] one edge after mem_write_ready rises, mem[0x10]=0x77.
REQ-038: Consumer 0 asserts read and write together -> read served first, write served in next grant of consumer 0 after rr rotation.
REQ-039: Assert reset while in READ_WAITING -> all outputs 0 asynchronously, busy=0; after release, no consumer_read_ready pulse for the aborted request.
REQ-040: Consumer 3 continuously requesting while 0..2 request repeatedly -> consumer 3 granted within 4 rounds.
